// File: rtl/hs32_arb_pkg.sv
// ---------------------------------------------------------------------------
// hs32_arb_pkg
// Shared types and constants for the hs32 core1 two-master bus arbiter.
//   arb_state_e     : arbiter FSM states (IDLE / WAIT)
//   arb_grant_e     : bus owner encoding (CPU = 0, WB = 1)
//   arb_req_t       : one downstream request (rw, addr, write data)
//   ARB_TIMEOUT_DEF : default number of WAIT cycles before an abort
//   arb_pick()      : round-robin choice between the eligible requesters
// ---------------------------------------------------------------------------
package hs32_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_WB  = 1'b1
    } arb_grant_e;

    localparam int ARB_TIMEOUT_DEF = 255;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] dtw;
    } arb_req_t;

    // Caller guarantees at least one requester is eligible. When both are,
    // the one that did not own the previous transaction wins.
    function automatic arb_grant_e arb_pick(
        input logic       cpu_ok,
        input logic       wb_ok,
        input arb_grant_e last
    );
        if (cpu_ok && wb_ok) begin
            return (last == GNT_WB) ? GNT_CPU : GNT_WB;
        end else if (wb_ok) begin
            return GNT_WB;
        end
        return GNT_CPU;
    endfunction

endpackage

// File: rtl/hs32_arb_req.sv
// ---------------------------------------------------------------------------
// hs32_arb_req
// Holding register for the CPU request. The CPU strobes for a single cycle,
// so its fields are captured here and kept until the arbiter acknowledges.
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_stb              : CPU request pulse
//   i_rw/i_addr/i_dtw  : request fields, valid with i_stb
//   i_clear            : arbiter is issuing o_cpu_ack this edge
//   o_pend             : a captured request is waiting or in flight
//   o_req              : captured request fields
// ---------------------------------------------------------------------------
module hs32_arb_req
    import hs32_arb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    input  logic        i_rw,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_dtw,
    input  logic        i_clear,
    output logic        o_pend,
    output arb_req_t    o_req
);

    logic     r_pend;
    arb_req_t r_req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend <= 1'b0;
            // NOTE: the data holding register is reset as well; it is only a
            // few flops and keeps the downstream bus free of X after reset.
            r_req  <= '0;
        end else if (i_clear) begin
            // A strobe in the ack cycle is ignored (pend is still set); the
            // CPU's next strobe, one cycle later, finds pend clear.
            r_pend <= 1'b0;
        end else if (i_stb && !r_pend) begin
            r_pend <= 1'b1;
            r_req  <= '{rw: i_rw, addr: i_addr, dtw: i_dtw};
        end
    end

    assign o_pend = r_pend;
    assign o_req  = r_req;

endmodule

// File: rtl/hs32_bus_arbiter.sv
// ---------------------------------------------------------------------------
// hs32_bus_arbiter
// Dynamic two-master (CPU / Caravel Wishbone) arbiter for the hs32 core1
// memory bus. One transaction at a time is issued downstream; the response
// is routed back to its owner. Round-robin on contention, a WB-only hold
// mode and a downstream ack timeout.
//   i_clk, i_reset               : clock, synchronous active-high reset
//   i_hold                       : 1 = only Wishbone may be granted
//   i_wb_stb/rw/addr/dtw         : Wishbone request, stb held until ack
//   o_wb_ack, o_wb_dtr           : Wishbone one-cycle ack and read data
//   i_cpu_stb/rw/addr/dtw        : CPU request, stb is a one-cycle pulse
//   o_cpu_ack, o_cpu_dtr         : CPU one-cycle ack and read data
//   o_stb, o_rw, o_addr, o_dtw   : downstream request (stb one-cycle pulse)
//   i_ack, i_dtr                 : downstream ack and read data
//   o_busy                       : transaction outstanding
//   o_grant                      : owner of current/last transaction
//   o_timeout                    : sticky abort flag
// ---------------------------------------------------------------------------
module hs32_bus_arbiter
    import hs32_arb_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_hold,
    input  logic        i_wb_stb,
    input  logic        i_wb_rw,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_dtw,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_dtr,
    input  logic        i_cpu_stb,
    input  logic        i_cpu_rw,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_dtw,
    output logic        o_cpu_ack,
    output logic [31:0] o_cpu_dtr,
    output logic        o_stb,
    output logic        o_rw,
    output logic [31:0] o_addr,
    output logic [31:0] o_dtw,
    input  logic        i_ack,
    input  logic [31:0] i_dtr,
    output logic        o_busy,
    output logic        o_grant,
    output logic        o_timeout
);

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    arb_state_e  r_state,      w_state_nxt;
    arb_grant_e  r_grant,      w_grant_nxt;
    arb_grant_e  r_last_grant, w_last_nxt;
    logic [15:0] r_timer,      w_timer_nxt;
    logic        r_stb,        w_stb_nxt;
    arb_req_t    r_req,        w_req_nxt;
    logic        r_wb_ack,     w_wb_ack_nxt;
    logic [31:0] r_wb_dtr,     w_wb_dtr_nxt;
    logic        r_cpu_ack,    w_cpu_ack_nxt;
    logic [31:0] r_cpu_dtr,    w_cpu_dtr_nxt;
    logic        r_timeout,    w_timeout_nxt;

    logic        w_cpu_pend;
    arb_req_t    w_cpu_req;
    logic        w_cpu_clear;
    logic        w_wb_ok;
    logic        w_cpu_ok;
    arb_grant_e  w_pick;
    logic        w_finish;
    logic [31:0] w_resp;

    hs32_arb_req u_cpu_req (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_stb   (i_cpu_stb),
        .i_rw    (i_cpu_rw),
        .i_addr  (i_cpu_addr),
        .i_dtw   (i_cpu_dtw),
        .i_clear (w_cpu_clear),
        .o_pend  (w_cpu_pend),
        .o_req   (w_cpu_req)
    );

    // WB still holds stb during its own ack cycle; masking with the ack
    // register prevents the same request from being issued twice.
    assign w_wb_ok  = i_wb_stb & ~r_wb_ack;
    assign w_cpu_ok = w_cpu_pend & ~i_hold;
    assign w_pick   = arb_pick(w_cpu_ok, w_wb_ok, r_last_grant);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ARB_IDLE;
            r_grant      <= GNT_CPU;
            r_last_grant <= GNT_WB;   // CPU wins the first contended cycle
            r_timer      <= '0;
            r_stb        <= 1'b0;
            r_req        <= '0;
            r_wb_ack     <= 1'b0;
            r_wb_dtr     <= '0;
            r_cpu_ack    <= 1'b0;
            r_cpu_dtr    <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_timer      <= w_timer_nxt;
            r_stb        <= w_stb_nxt;
            r_req        <= w_req_nxt;
            r_wb_ack     <= w_wb_ack_nxt;
            r_wb_dtr     <= w_wb_dtr_nxt;
            r_cpu_ack    <= w_cpu_ack_nxt;
            r_cpu_dtr    <= w_cpu_dtr_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last_grant;
        w_timer_nxt   = r_timer;
        w_stb_nxt     = 1'b0;
        w_req_nxt     = r_req;
        w_wb_ack_nxt  = 1'b0;
        w_wb_dtr_nxt  = r_wb_dtr;
        w_cpu_ack_nxt = 1'b0;
        w_cpu_dtr_nxt = r_cpu_dtr;
        w_timeout_nxt = r_timeout;
        w_cpu_clear   = 1'b0;
        w_finish      = 1'b0;
        w_resp        = '0;

        case (r_state)
            ARB_IDLE: begin
                if (w_wb_ok || w_cpu_ok) begin
                    w_state_nxt = ARB_WAIT;
                    w_stb_nxt   = 1'b1;
                    w_grant_nxt = w_pick;
                    w_last_nxt  = w_pick;
                    w_timer_nxt = '0;
                    w_req_nxt   = (w_pick == GNT_WB)
                                ? '{rw: i_wb_rw, addr: i_wb_addr, dtw: i_wb_dtw}
                                : w_cpu_req;
                end
            end
            ARB_WAIT: begin
                // A real ack takes priority over an abort in the same cycle.
                if (i_ack) begin
                    w_finish = 1'b1;
                    w_resp   = i_dtr;
                end else if (r_timer == TIMEOUT_W) begin
                    w_finish      = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else if (r_timer != 16'hFFFF) begin
                    w_timer_nxt = r_timer + 16'd1;
                end

                if (w_finish) begin
                    w_state_nxt = ARB_IDLE;
                    if (r_grant == GNT_WB) begin
                        w_wb_ack_nxt = 1'b1;
                        w_wb_dtr_nxt = w_resp;
                    end else begin
                        w_cpu_ack_nxt = 1'b1;
                        w_cpu_dtr_nxt = w_resp;
                        w_cpu_clear   = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    assign o_stb     = r_stb;
    assign o_rw      = r_req.rw;
    assign o_addr    = r_req.addr;
    assign o_dtw     = r_req.dtw;
    assign o_wb_ack  = r_wb_ack;
    assign o_wb_dtr  = r_wb_dtr;
    assign o_cpu_ack = r_cpu_ack;
    assign o_cpu_dtr = r_cpu_dtr;
    assign o_busy    = (r_state == ARB_WAIT);
    assign o_grant   = r_grant;
    assign o_timeout = r_timeout;

endmodule
